mark_table: RTL and testbench

- Holds the "value already used" bitmaps for the sudoku solver: one 9-bit mask per row, per column and per 3x3 box.
- The backtracking controller sets a mark when it places a digit and clears it when it backtracks.
- It reads back the three mark bits for a (row, col, value) triple.
- The registered read outputs drive the row/col/matrix mark inputs of the downstream compare stage directly.

---
 rtl/mark_table.sv | 159 +++++++++++++++
 tb/tb_mark_table.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/mark_table.sv
// Row / column / box "digit already used" bitmaps for the sudoku solver, with
// single-cycle read, set, clear and a 9-cycle clear-all sweep.
// Optional placed-digit counter: define MARK_TABLE_COUNT_EN to add o_mark_cnt.
module mark_table #(
  parameter int N     = 9,
  parameter int BOX   = 3,
  parameter int IDX_W = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_req,
  input  logic [1:0]       i_op,
  input  logic [IDX_W-1:0] i_row,
  input  logic [IDX_W-1:0] i_col,
  input  logic [IDX_W-1:0] i_val,
  output logic             o_busy,
  output logic             o_rdvalid,
  output logic             o_rddata_mark_row,
  output logic             o_rddata_mark_col,
  output logic             o_rddata_mark_matrix,
`ifdef MARK_TABLE_COUNT_EN
  output logic [6:0]       o_mark_cnt,
`endif
  output logic             o_err
);

  localparam logic [1:0]       OP_READ  = 2'b00;
  localparam logic [1:0]       OP_SET   = 2'b01;
  localparam logic [1:0]       OP_CLR   = 2'b10;
  localparam logic [1:0]       OP_CLRALL = 2'b11;
  localparam logic [IDX_W-1:0] N_L      = IDX_W'(N);
  localparam logic [IDX_W-1:0] LAST_L   = IDX_W'(N - 1);
  localparam logic [IDX_W-1:0] BOX_L    = IDX_W'(BOX);
  localparam logic [IDX_W-1:0] BOX2_L   = IDX_W'(2 * BOX);
  localparam logic [IDX_W-1:0] ONE_L    = IDX_W'(1);

  typedef enum logic [0:0] {IDLE, SWEEP} state_t;

  state_t           state;
  logic [IDX_W-1:0] cnt;
  logic [N-1:0]     row_mask [N];
  logic [N-1:0]     col_mask [N];
  logic [N-1:0]     box_mask [N];

  // Box group by comparison so no divider is inferred.
  function automatic logic [IDX_W-1:0] box_group(input logic [IDX_W-1:0] idx);
    if (idx < BOX_L)       return '0;
    else if (idx < BOX2_L) return ONE_L;
    else                   return IDX_W'(2);
  endfunction

  logic             row_ok, col_ok, val_ok, legal;
  logic [IDX_W-1:0] row_i, col_i, box_i, bit_i;
  logic             cur_r, cur_c, cur_b;

  always_comb begin
    row_ok = (i_row < N_L);
    col_ok = (i_col < N_L);
    val_ok = (i_val >= ONE_L) && (i_val <= N_L);
    legal  = val_ok && ((i_op == OP_CLRALL) || (row_ok && col_ok));
    // Clamp indices so illegal requests never address outside the tables.
    row_i  = row_ok ? i_row : '0;
    col_i  = col_ok ? i_col : '0;
    bit_i  = val_ok ? (i_val - ONE_L) : '0;
    box_i  = box_group(row_i) * BOX_L + box_group(col_i);
    cur_r  = row_mask[row_i][bit_i];
    cur_c  = col_mask[col_i][bit_i];
    cur_b  = box_mask[box_i][bit_i];
  end

`ifdef MARK_TABLE_COUNT_EN
  localparam logic [6:0] MAX_CNT = 7'(N * N);
  logic [6:0] mark_cnt;
  assign o_mark_cnt = mark_cnt;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state                <= IDLE;
      cnt                  <= '0;
      o_busy               <= 1'b0;
      o_rdvalid            <= 1'b0;
      o_err                <= 1'b0;
      o_rddata_mark_row    <= 1'b0;
      o_rddata_mark_col    <= 1'b0;
      o_rddata_mark_matrix <= 1'b0;
      for (int i = 0; i < N; i++) begin
        row_mask[i] <= '0;
        col_mask[i] <= '0;
        box_mask[i] <= '0;
      end
`ifdef MARK_TABLE_COUNT_EN
      mark_cnt <= '0;
`endif
    end else begin
      o_rdvalid <= 1'b0;
      o_err     <= 1'b0;
      case (state)
        IDLE: begin
          if (i_req) begin
            if (!legal) begin
              o_err <= 1'b1;
            end else begin
              case (i_op)
                OP_READ: begin
                  o_rddata_mark_row    <= cur_r;
                  o_rddata_mark_col    <= cur_c;
                  o_rddata_mark_matrix <= cur_b;
                  o_rdvalid            <= 1'b1;
                end
                OP_SET: begin
                  row_mask[row_i][bit_i] <= 1'b1;
                  col_mask[col_i][bit_i] <= 1'b1;
                  box_mask[box_i][bit_i] <= 1'b1;
                  o_err <= cur_r | cur_c | cur_b;
`ifdef MARK_TABLE_COUNT_EN
                  if (!(cur_r | cur_c | cur_b) && (mark_cnt < MAX_CNT))
                    mark_cnt <= mark_cnt + 7'd1;
`endif
                end
                OP_CLR: begin
                  row_mask[row_i][bit_i] <= 1'b0;
                  col_mask[col_i][bit_i] <= 1'b0;
                  box_mask[box_i][bit_i] <= 1'b0;
                  o_err <= ~(cur_r & cur_c & cur_b);
`ifdef MARK_TABLE_COUNT_EN
                  if ((cur_r & cur_c & cur_b) && (mark_cnt != 7'd0))
                    mark_cnt <= mark_cnt - 7'd1;
`endif
                end
                default: begin
                  state  <= SWEEP;
                  cnt    <= '0;
                  o_busy <= 1'b1;
`ifdef MARK_TABLE_COUNT_EN
                  mark_cnt <= '0;
`endif
                end
              endcase
            end
          end
        end
        default: begin
          // Requests are dropped silently while the sweep runs.
          row_mask[cnt] <= '0;
          col_mask[cnt] <= '0;
          box_mask[cnt] <= '0;
          if (cnt == LAST_L) begin
            state  <= IDLE;
            o_busy <= 1'b0;
          end else begin
            cnt <= cnt + ONE_L;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mark_table.sv
// Scoreboard bench for mark_table: stimulus pushes expected responses, a
// monitor pops and compares on every o_rdvalid / o_err pulse.
module tb_mark_table;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req = 1'b0;
  logic [1:0] op  = 2'b00;
  logic [3:0] row = 4'd0;
  logic [3:0] col = 4'd0;
  logic [3:0] val = 4'd0;
  logic       busy, rdvalid, mrow, mcol, mmat, err;
`ifdef MARK_TABLE_COUNT_EN
  logic [6:0] mark_cnt;
`endif

  mark_table dut (
    .i_clk(clk), .i_rst(rst), .i_req(req), .i_op(op),
    .i_row(row), .i_col(col), .i_val(val),
    .o_busy(busy), .o_rdvalid(rdvalid),
    .o_rddata_mark_row(mrow), .o_rddata_mark_col(mcol),
    .o_rddata_mark_matrix(mmat),
`ifdef MARK_TABLE_COUNT_EN
    .o_mark_cnt(mark_cnt),
`endif
    .o_err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       is_err;
    logic [2:0] marks;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   checks = 0;
  int   passed = 0;
  int   busy_n;

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got == want) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, got, want);
  endtask

  task automatic drive(input logic [1:0] o, input int r, input int c, input int v);
    @(negedge clk);
    req = 1'b1; op = o; row = 4'(r); col = 4'(c); val = 4'(v);
  endtask

  task automatic rd(input string name, input int r, input int c, input int v, input logic [2:0] m);
    drive(2'b00, r, c, v);
    sb.push_back('{name, 1'b0, m});
    $display("issue %s: read r=%0d c=%0d v=%0d expect marks=%03b", name, r, c, v, m);
  endtask

  task automatic wr(input string name, input logic [1:0] o, input int r, input int c, input int v, input bit expect_err);
    drive(o, r, c, v);
    if (expect_err) sb.push_back('{name, 1'b1, 3'b000});
    $display("issue %s: op=%0d r=%0d c=%0d v=%0d expect err=%0b", name, o, r, c, v, expect_err);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      req = 1'b0;
    end
  endtask

  // Monitor: every response must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && (rdvalid || err)) begin
      checks++;
      if (sb.size() == 0) begin
        $display("FAIL unexpected_response: got rdvalid=%0b err=%0b, expected none", rdvalid, err);
      end else begin
        e = sb.pop_front();
        if ((rdvalid == !e.is_err) && (err == e.is_err) &&
            (e.is_err || ({mrow, mcol, mmat} == e.marks))) begin
          passed++;
          $display("resp %s: rdvalid=%0b err=%0b marks=%03b ok", e.name, rdvalid, err, {mrow, mcol, mmat});
        end else begin
          $display("FAIL %s: got rdvalid=%0b err=%0b marks=%03b, expected rdvalid=%0b err=%0b marks=%03b",
                   e.name, rdvalid, err, {mrow, mcol, mmat}, !e.is_err, e.is_err, e.marks);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    check("reset_busy", int'(busy), 0);
    check("reset_rdvalid", int'(rdvalid), 0);
    check("reset_err", int'(err), 0);
    check("reset_marks", int'({mrow, mcol, mmat}), 0);
    rst = 1'b0;

    rd("rd_after_reset", 0, 0, 5, 3'b000);
    wr("set_4_7_3", 2'b01, 4, 7, 3, 1'b0);
    rd("rd_row_hit", 4, 2, 3, 3'b100);
    rd("rd_box5_hit", 3, 6, 3, 3'b001);
    rd("rd_col_hit", 8, 7, 3, 3'b010);
    wr("set_dup", 2'b01, 4, 7, 3, 1'b1);
    idle(2);
`ifdef MARK_TABLE_COUNT_EN
    check("cnt_after_dup", int'(mark_cnt), 1);
`endif
    wr("clr_4_7_3", 2'b10, 4, 7, 3, 1'b0);
    idle(2);
`ifdef MARK_TABLE_COUNT_EN
    check("cnt_after_clr", int'(mark_cnt), 0);
`endif
    rd("rd_after_clr", 4, 7, 3, 3'b000);
    wr("clr_again", 2'b10, 4, 7, 3, 1'b1);

    wr("ill_val0", 2'b00, 0, 0, 0, 1'b1);
    wr("ill_val10", 2'b01, 0, 0, 10, 1'b1);
    wr("ill_row9", 2'b01, 9, 0, 1, 1'b1);
    rd("rd_no_change", 0, 0, 1, 3'b000);

    wr("set_a", 2'b01, 0, 0, 1, 1'b0);
    wr("set_b", 2'b01, 1, 4, 2, 1'b0);
    wr("set_c", 2'b01, 5, 5, 9, 1'b0);
    wr("set_d", 2'b01, 8, 8, 7, 1'b0);
    wr("set_e", 2'b01, 2, 6, 4, 1'b0);
    rd("rd_c_set", 5, 5, 9, 3'b111);
    wr("clear_all", 2'b11, 0, 0, 1, 1'b0);
    busy_n = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (i == 0) begin
        req = 1'b1; op = 2'b00; row = 4'd0; col = 4'd0; val = 4'd1;
      end else begin
        req = 1'b0;
      end
      if (busy) busy_n++;
    end
    check("busy_cycles", busy_n, 9);
    rd("rd_a_swept", 0, 0, 1, 3'b000);
    rd("rd_b_swept", 1, 4, 2, 3'b000);
    rd("rd_c_swept", 5, 5, 9, 3'b000);
    rd("rd_d_swept", 8, 8, 7, 3'b000);
    rd("rd_e_swept", 2, 6, 4, 3'b000);

    wr("set_3_3_3", 2'b01, 3, 3, 3, 1'b0);
    wr("set_8_8_9", 2'b01, 8, 8, 9, 1'b0);
    rd("rd_3_3_3", 3, 3, 3, 3'b111);
    wr("clear_all_2", 2'b11, 0, 0, 1, 1'b0);
    idle(4);
    check("mid_sweep_busy", int'(busy), 1);
    rst = 1'b1;
    #1;
    check("abort_busy", int'(busy), 0);
    check("abort_marks", int'({mrow, mcol, mmat}), 0);
    check("abort_err_rdvalid", int'({err, rdvalid}), 0);
    @(negedge clk);
    rst = 1'b0;
    rd("rd_after_abort", 8, 8, 9, 3'b000);
    wr("set_after_abort", 2'b01, 8, 8, 9, 1'b0);
    rd("rd_after_set", 8, 8, 9, 3'b111);
    idle(4);
    check("scoreboard_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
